rocc_shared_arbiter: RTL and testbench

Shares one RoCC accelerator between `NREQ` cores (RoCC requesters) over the command/response channels. It round-robin arbitrates incoming commands onto the single accelerator command port. It records the issuing requester and destination `rd` for every command that expects a response, then routes accelerator responses back in issue order. It sits between the tiles' RoCC command/response wiring and one accelerator instance; the memory and FPU channels are not arbitrated.

---
 rtl/rocc_shared_arbiter_if.sv | 55 +++++
 rtl/rocc_shared_arbiter.sv | 148 ++++++++++++++
 tb/tb_rocc_shared_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rocc_shared_arbiter_if.sv
// Requester-side and accelerator-side RoCC command/response wiring for rocc_shared_arbiter.
// Handshake: a transfer happens on a clock edge where valid && ready; valid must hold with stable fields until then.
interface rocc_shared_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 64
);
  logic [NREQ-1:0]      req_cmd_valid;
  logic [NREQ-1:0]      req_cmd_ready;
  logic [7*NREQ-1:0]    req_cmd_funct;
  logic [5*NREQ-1:0]    req_cmd_rd;
  logic [NREQ-1:0]      req_cmd_xd;
  logic [XLEN*NREQ-1:0] req_cmd_rs1;
  logic [XLEN*NREQ-1:0] req_cmd_rs2;
  logic [NREQ-1:0]      req_resp_valid;
  logic [NREQ-1:0]      req_resp_ready;
  logic [5*NREQ-1:0]    req_resp_rd;
  logic [XLEN*NREQ-1:0] req_resp_data;
  logic [NREQ-1:0]      req_busy;
  logic                 acc_cmd_valid;
  logic                 acc_cmd_ready;
  logic [6:0]           acc_cmd_funct;
  logic [4:0]           acc_cmd_rd;
  logic                 acc_cmd_xd;
  logic [XLEN-1:0]      acc_cmd_rs1;
  logic [XLEN-1:0]      acc_cmd_rs2;
  logic                 acc_resp_valid;
  logic                 acc_resp_ready;
  logic [4:0]           acc_resp_rd;
  logic [XLEN-1:0]      acc_resp_data;
  logic                 acc_busy;

  // The arbiter itself.
  modport slave (
    input  req_cmd_valid, req_cmd_funct, req_cmd_rd, req_cmd_xd, req_cmd_rs1, req_cmd_rs2,
    output req_cmd_ready,
    output req_resp_valid, req_resp_rd, req_resp_data, req_busy,
    input  req_resp_ready,
    output acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
    input  acc_cmd_ready,
    input  acc_resp_valid, acc_resp_rd, acc_resp_data, acc_busy,
    output acc_resp_ready
  );

  // The surrounding cores and accelerator.
  modport master (
    output req_cmd_valid, req_cmd_funct, req_cmd_rd, req_cmd_xd, req_cmd_rs1, req_cmd_rs2,
    input  req_cmd_ready,
    input  req_resp_valid, req_resp_rd, req_resp_data, req_busy,
    output req_resp_ready,
    input  acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
    output acc_cmd_ready,
    output acc_resp_valid, acc_resp_rd, acc_resp_data, acc_busy,
    input  acc_resp_ready
  );
endinterface

// File: rtl/rocc_shared_arbiter.sv
// Shares one RoCC accelerator between NREQ cores: round-robin command arbitration, in-order response routing.
// Optional ROCC_ARB_RESP_CHECK_EN adds a sticky resp_err flag for rd mismatches and unexpected responses.
module rocc_shared_arbiter #(
  parameter int NREQ  = 2,
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  rocc_shared_arbiter_if.slave bus
`ifdef ROCC_ARB_RESP_CHECK_EN
  ,
  output logic resp_err
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant;
  logic            grant_valid;
  logic [NREQ-1:0] eligible;
  logic [6:0]      funct_a [NREQ];
  logic [4:0]      rd_a    [NREQ];
  logic [XLEN-1:0] rs1_a   [NREQ];
  logic [XLEN-1:0] rs2_a   [NREQ];

  logic [IW-1:0]   fifo_id [DEPTH];
  logic [4:0]      fifo_rd [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding [NREQ];
  logic            full, empty, cmd_fire, push, pop;
  logic [IW-1:0]   head_id;
  logic [4:0]      head_rd;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign eligible = bus.req_cmd_valid & (~bus.req_cmd_xd | {NREQ{~full}});
  assign head_id  = fifo_id[rd_ptr];
  assign head_rd  = fifo_rd[rd_ptr];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      funct_a[i] = bus.req_cmd_funct[i*7 +: 7];
      rd_a[i]    = bus.req_cmd_rd[i*5 +: 5];
      rs1_a[i]   = bus.req_cmd_rs1[i*XLEN +: XLEN];
      rs2_a[i]   = bus.req_cmd_rs2[i*XLEN +: XLEN];
    end
  end

  // First eligible requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    logic [IW-1:0] idx_w;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IW'(idx);
      if (!grant_valid && eligible[idx_w]) begin
        grant_valid = 1'b1;
        grant       = idx_w;
      end
    end
  end

  always_comb begin
    bus.acc_cmd_valid = grant_valid;
    bus.acc_cmd_funct = funct_a[grant];
    bus.acc_cmd_rd    = rd_a[grant];
    bus.acc_cmd_xd    = bus.req_cmd_xd[grant];
    bus.acc_cmd_rs1   = rs1_a[grant];
    bus.acc_cmd_rs2   = rs2_a[grant];
    bus.req_cmd_ready = '0;
    if (grant_valid) bus.req_cmd_ready[grant] = bus.acc_cmd_ready;
  end

  // An empty tracker means the response is unexpected: sink it so the accelerator never stalls.
  always_comb begin
    bus.req_resp_valid = '0;
    bus.req_resp_rd    = {NREQ{head_rd}};
    bus.req_resp_data  = {NREQ{bus.acc_resp_data}};
    bus.acc_resp_ready = 1'b1;
    if (!empty) begin
      bus.req_resp_valid[head_id] = bus.acc_resp_valid;
      bus.acc_resp_ready          = bus.req_resp_ready[head_id];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) bus.req_busy[i] = (outstanding[i] != '0) | bus.acc_busy;
  end

  assign cmd_fire = grant_valid & bus.acc_cmd_ready;
  assign push     = cmd_fire & bus.acc_cmd_xd;
  assign pop      = bus.acc_resp_valid & bus.acc_resp_ready & ~empty;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_id[wr_ptr] <= grant;
      fifo_rd[wr_ptr] <= rd_a[grant];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
    end else begin
      if (cmd_fire) ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < NREQ; i++) begin
        if ((push && grant == IW'(i)) && !(pop && head_id == IW'(i)))
          outstanding[i] <= outstanding[i] + 1'b1;
        else if (!(push && grant == IW'(i)) && (pop && head_id == IW'(i)))
          outstanding[i] <= outstanding[i] - 1'b1;
      end
    end
  end

`ifdef ROCC_ARB_RESP_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if ((pop && bus.acc_resp_rd != head_rd) || (bus.acc_resp_valid && empty)) begin
      resp_err <= 1'b1;
    end
  end
`else
  logic unused_resp_rd;
  assign unused_resp_rd = ^bus.acc_resp_rd;
`endif
endmodule

// File: tb/tb_rocc_shared_arbiter.sv
// Bench for rocc_shared_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_rocc_shared_arbiter;
  localparam int NREQ  = 3;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rocc_shared_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();
`ifdef ROCC_ARB_RESP_CHECK_EN
  logic resp_err;
`endif

  rocc_shared_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ROCC_ARB_RESP_CHECK_EN
    ,
    .resp_err (resp_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Outstanding responses in issue order: {requester[2:0], rd[4:0]}.
  logic [7:0] exp_q[$];
  int ptr_m = 0;
  bit err_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending(input int r);
    int n = 0;
    foreach (exp_q[j]) if (int'(exp_q[j][7:5]) == r) n++;
    return n;
  endfunction

  task automatic set_cmd(input int i, input bit v, input bit xd, input logic [4:0] rd, input logic [6:0] funct);
    bus.req_cmd_valid[i]              = v;
    bus.req_cmd_xd[i]                 = xd;
    bus.req_cmd_rd[i*5 +: 5]          = rd;
    bus.req_cmd_funct[i*7 +: 7]       = funct;
    bus.req_cmd_rs1[i*XLEN +: XLEN]   = $urandom;
    bus.req_cmd_rs2[i*XLEN +: XLEN]   = $urandom;
  endtask

  task automatic settle();
    #1;
  endtask

  // Checks every output against the model for the current inputs, then advances the model one edge.
  task automatic cycle();
    int g, h;
    bit full, cmd_fire, resp_fire, push_xd;
    logic [4:0] push_rd, resp_rd_in;
    logic [NREQ-1:0] cr_exp, rv_exp, busy_exp;
    #1;
    full = (exp_q.size() == DEPTH);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr_m + k) % NREQ;
      if (g < 0 && bus.req_cmd_valid[i] && (!bus.req_cmd_xd[i] || !full)) g = i;
    end
    check("acc_cmd_valid", bus.acc_cmd_valid, g >= 0);
    cr_exp = '0;
    push_xd = 1'b0;
    push_rd = '0;
    if (g >= 0) begin
      cr_exp[g] = bus.acc_cmd_ready;
      push_xd = bus.req_cmd_xd[g];
      push_rd = bus.req_cmd_rd[g*5 +: 5];
      check("acc_cmd_ctl", {bus.acc_cmd_funct, bus.acc_cmd_rd, bus.acc_cmd_xd},
            {bus.req_cmd_funct[g*7 +: 7], bus.req_cmd_rd[g*5 +: 5], bus.req_cmd_xd[g]});
      check("acc_cmd_rs1", bus.acc_cmd_rs1, bus.req_cmd_rs1[g*XLEN +: XLEN]);
      check("acc_cmd_rs2", bus.acc_cmd_rs2, bus.req_cmd_rs2[g*XLEN +: XLEN]);
    end
    check("req_cmd_ready", bus.req_cmd_ready, cr_exp);

    h = -1;
    if (exp_q.size() > 0) h = int'(exp_q[0][7:5]);
    rv_exp = '0;
    if (h >= 0) begin
      rv_exp[h] = bus.acc_resp_valid;
      check("acc_resp_ready", bus.acc_resp_ready, bus.req_resp_ready[h]);
      check("req_resp_rd", bus.req_resp_rd[h*5 +: 5], exp_q[0][4:0]);
    end else begin
      check("acc_resp_ready_empty", bus.acc_resp_ready, 1'b1);
    end
    check("req_resp_valid", bus.req_resp_valid, rv_exp);
    for (int i = 0; i < NREQ; i++)
      check("req_resp_data", bus.req_resp_data[i*XLEN +: XLEN], bus.acc_resp_data);
    for (int i = 0; i < NREQ; i++) busy_exp[i] = (pending(i) != 0) || bus.acc_busy;
    check("req_busy", bus.req_busy, busy_exp);
`ifdef ROCC_ARB_RESP_CHECK_EN
    check("resp_err", resp_err, err_m);
`endif

    cmd_fire   = (g >= 0) && bus.acc_cmd_ready;
    resp_fire  = bus.acc_resp_valid && (h < 0 || bus.req_resp_ready[h]);
    resp_rd_in = bus.acc_resp_rd;
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      ptr_m = 0;
      err_m = 1'b0;
    end else begin
      if (resp_fire) begin
        if (h < 0) err_m = 1'b1;
        else begin
          if (resp_rd_in != exp_q[0][4:0]) err_m = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      if (cmd_fire) begin
        ptr_m = (g + 1) % NREQ;
        if (push_xd) exp_q.push_back({3'(g), push_rd});
      end
    end
    @(negedge clock);
  endtask

  initial begin
    reset              = 1'b1;
    bus.req_cmd_valid  = '0;
    bus.req_cmd_funct  = '0;
    bus.req_cmd_rd     = '0;
    bus.req_cmd_xd     = '0;
    bus.req_cmd_rs1    = '0;
    bus.req_cmd_rs2    = '0;
    bus.req_resp_ready = '0;
    bus.acc_cmd_ready  = 1'b0;
    bus.acc_resp_valid = 1'b0;
    bus.acc_resp_rd    = '0;
    bus.acc_resp_data  = '0;
    bus.acc_busy       = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    settle();
    check("rst_cmd_valid", bus.acc_cmd_valid, 1'b0);
    check("rst_resp_ready", bus.acc_resp_ready, 1'b1);
    check("rst_busy", bus.req_busy, 3'b000);
    bus.acc_busy = 1'b1;
    settle();
    check("rst_busy_acc", bus.req_busy, 3'b111);
    bus.acc_busy = 1'b0;
    cycle();

    // Round-robin over three always-valid requesters
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 1'b0, 5'd0, 7'(10 + i));
    bus.acc_cmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("rr_grant", bus.acc_cmd_funct, 7'(10 + k % 3));
      cycle();
    end

    // Ordered routing: req1 rd5 then req0 rd9
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 1'b0, 5'd0, 7'd0);
    set_cmd(1, 1'b1, 1'b1, 5'd5, 7'd1);
    cycle();
    set_cmd(1, 1'b0, 1'b0, 5'd0, 7'd0);
    set_cmd(0, 1'b1, 1'b1, 5'd9, 7'd2);
    cycle();
    set_cmd(0, 1'b0, 1'b0, 5'd0, 7'd0);
    bus.req_resp_ready = 3'b111;
    bus.acc_resp_valid = 1'b1;
    bus.acc_resp_rd    = 5'd5;
    bus.acc_resp_data  = 32'hA;
    settle();
    check("route1_valid", bus.req_resp_valid, 3'b010);
    check("route1_rd", bus.req_resp_rd[9:5], 5'd5);
    check("route1_data", bus.req_resp_data[63:32], 32'hA);
    check("route1_busy", bus.req_busy, 3'b011);
    cycle();
    bus.acc_resp_rd   = 5'd9;
    bus.acc_resp_data = 32'hB;
    settle();
    check("route2_valid", bus.req_resp_valid, 3'b001);
    check("route2_rd", bus.req_resp_rd[4:0], 5'd9);
    check("route2_data", bus.req_resp_data[31:0], 32'hB);
    cycle();
    bus.acc_resp_valid = 1'b0;
    settle();
    check("route_idle_busy", bus.req_busy, 3'b000);
    cycle();

    // Full tracker: four xd=1 from req2, then xd=1 (req0) and xd=0 (req1)
    set_cmd(2, 1'b1, 1'b1, 5'd3, 7'd3);
    repeat (4) cycle();
    set_cmd(2, 1'b0, 1'b0, 5'd0, 7'd0);
    set_cmd(0, 1'b1, 1'b1, 5'd4, 7'd4);
    set_cmd(1, 1'b1, 1'b0, 5'd0, 7'd5);
    settle();
    check("full_xd0_ready", bus.req_cmd_ready, 3'b010);
    check("full_xd0_xd", bus.acc_cmd_xd, 1'b0);
    cycle();
    set_cmd(1, 1'b0, 1'b0, 5'd0, 7'd0);
    settle();
    check("full_stall", bus.acc_cmd_valid, 1'b0);
    bus.acc_resp_valid = 1'b1;
    bus.acc_resp_rd    = 5'd3;
    settle();
    check("full_no_bypass", bus.acc_cmd_valid, 1'b0);
    check("full_pop_ready", bus.acc_resp_ready, 1'b1);
    cycle();
    bus.acc_resp_valid = 1'b0;
    settle();
    check("full_release_valid", bus.acc_cmd_valid, 1'b1);
    check("full_release_ready", bus.req_cmd_ready, 3'b001);
    cycle();
    set_cmd(0, 1'b0, 1'b0, 5'd0, 7'd0);

    // Backpressure from head requester (req2)
    bus.acc_resp_valid = 1'b1;
    bus.acc_resp_data  = 32'h55;
    bus.req_resp_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_acc_ready", bus.acc_resp_ready, 1'b0);
      check("bp_valid", bus.req_resp_valid, 3'b100);
      check("bp_data", bus.req_resp_data[95:64], 32'h55);
      cycle();
    end
    bus.req_resp_ready = 3'b100;
    cycle();
    bus.acc_resp_valid = 1'b0;
    bus.req_resp_ready = 3'b111;

    // Reset with responses outstanding, then an unexpected response
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.acc_busy = 1'b1;
    settle();
    check("rst2_busy_acc", bus.req_busy, 3'b111);
    bus.acc_busy = 1'b0;
    settle();
    check("rst2_busy", bus.req_busy, 3'b000);
    bus.acc_resp_valid = 1'b1;
    bus.acc_resp_rd    = 5'd1;
    settle();
    check("unexp_ready", bus.acc_resp_ready, 1'b1);
    check("unexp_valid", bus.req_resp_valid, 3'b000);
    cycle();
    bus.acc_resp_valid = 1'b0;
`ifdef ROCC_ARB_RESP_CHECK_EN
    settle();
    check("unexp_err", resp_err, 1'b1);
`endif
    cycle();

    // Rd mismatch: tracked rd 7, accelerator reports 3
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_cmd(0, 1'b1, 1'b1, 5'd7, 7'd6);
    cycle();
    set_cmd(0, 1'b0, 1'b0, 5'd0, 7'd0);
    bus.acc_resp_valid = 1'b1;
    bus.acc_resp_rd    = 5'd3;
    settle();
    check("mism_rd", bus.req_resp_rd[4:0], 5'd7);
    check("mism_valid", bus.req_resp_valid, 3'b001);
    cycle();
    bus.acc_resp_valid = 1'b0;
`ifdef ROCC_ARB_RESP_CHECK_EN
    settle();
    check("mism_err", resp_err, 1'b1);
`endif
    cycle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)));
      bus.acc_cmd_ready  = ($urandom_range(0, 3) != 0);
      bus.acc_resp_valid = 1'($urandom_range(0, 1));
      bus.acc_resp_rd    = 5'($urandom_range(0, 31));
      bus.acc_resp_data  = $urandom;
      bus.req_resp_ready = 3'($urandom_range(0, 7));
      bus.acc_busy       = ($urandom_range(0, 7) == 0);
      reset              = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
